// File: rtl/tl_ul_sram_slave_pkg.sv
// Shared TileLink UL widths, opcode constants and the D-channel response record
// used by the SRAM responder and its response FIFO.
package tl_ul_sram_slave_pkg;

  localparam int TL_ADDR_BITS   = 32;
  localparam int TL_DATA_BYTES  = 4;
  localparam int TL_DATA_BITS   = TL_DATA_BYTES * 8;
  localparam int TL_SIZE_BITS   = 3;
  localparam int TL_SOURCE_BITS = 4;
  localparam int TL_SINK_BITS   = 1;

  localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_A_GET             = 3'd4;
  localparam logic [3:0] TL_D_ACCESS_ACK      = 4'd0;
  localparam logic [3:0] TL_D_ACCESS_ACK_DATA = 4'd1;

  // One queued D-channel beat; d_param and d_sink are constants and not stored.
  typedef struct packed {
    logic [3:0]                opcode;
    logic [TL_SIZE_BITS-1:0]   size;
    logic [TL_SOURCE_BITS-1:0] source;
    logic                      denied;
    logic [TL_DATA_BITS-1:0]   data;
  } tl_d_resp_t;

  localparam int RESP_W = $bits(tl_d_resp_t);

  function automatic logic is_put_op(input logic [2:0] op);
    return (op == TL_A_PUT_FULL) || (op == TL_A_PUT_PARTIAL);
  endfunction

endpackage

// File: rtl/tl_resp_fifo.sv
// Two-entry response FIFO with a dedicated head register so the D channel is
// driven straight from flops; push and pop in the same cycle keep the count.
module tl_resp_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic [W-1:0] push_data_i,
  output logic         pop_valid_o,
  input  logic         pop_ready_i,
  output logic [W-1:0] pop_data_o,
  output logic [1:0]   count_o
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push, pop;

  // valid/ready: a beat moves when valid and ready are both high at the rising edge;
  // ready depends on registered count only, never on the partner's valid.
  assign push_ready_o = (count_q != 2'd2);
  assign pop_valid_o  = (count_q != 2'd0);
  assign push         = push_valid_i && push_ready_o;
  assign pop          = pop_valid_o && pop_ready_i;
  assign pop_data_o   = head_q;
  assign count_o      = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop && (count_q == 2'd2)) begin
      head_d = tail_q;
    end
    // A push lands in the head slot only when that slot is empty after this cycle's pop.
    if (push) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
        head_d = push_data_i;
      end else begin
        tail_d = push_data_i;
      end
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/tl_ul_sram_slave.sv
// TileLink UL responder terminating Channel A at an on-chip SRAM word array.
// Define TL_SLAVE_ERR_EN to deny bad opcodes, sizes, alignments and addresses.
module tl_ul_sram_slave
  import tl_ul_sram_slave_pkg::*;
#(
  parameter int                       DEPTH     = 256,
  parameter logic [TL_ADDR_BITS-1:0]  BASE_ADDR = '0,
  parameter logic [TL_SINK_BITS-1:0]  SINK_ID   = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                a_opcode,
  input  logic [2:0]                a_param,
  input  logic [TL_SIZE_BITS-1:0]   a_size,
  input  logic [TL_SOURCE_BITS-1:0] a_source,
  input  logic [TL_ADDR_BITS-1:0]   a_address,
  input  logic [TL_DATA_BYTES-1:0]  a_mask,
  input  logic [TL_DATA_BITS-1:0]   a_data,
  input  logic                      a_valid,
  output logic                      a_ready,
  output logic [3:0]                d_opcode,
  output logic [1:0]                d_param,
  output logic [TL_SIZE_BITS-1:0]   d_size,
  output logic [TL_SOURCE_BITS-1:0] d_source,
  output logic [TL_SINK_BITS-1:0]   d_sink,
  output logic                      d_denied,
  output logic [TL_DATA_BITS-1:0]   d_data,
  output logic                      d_valid,
  input  logic                      d_ready
);

  localparam int OFF_BITS = $clog2(TL_DATA_BYTES);
  localparam int IDX_BITS = $clog2(DEPTH);

  logic                    a_hs;
  logic [TL_ADDR_BITS-1:0] offset;
  logic [TL_ADDR_BITS-1:0] word_no;
  logic [IDX_BITS-1:0]     idx;
  logic                    op_put;
  logic                    op_get;
  logic                    denied;
  logic [TL_DATA_BITS-1:0] rdata;
  tl_d_resp_t              resp_in;
  tl_d_resp_t              resp_head;
  logic [1:0]              fifo_count;
  logic                    unused_bits;

  logic [TL_DATA_BITS-1:0] mem_q [DEPTH];

  assign offset  = a_address - BASE_ADDR;
  assign word_no = offset >> OFF_BITS;
  assign idx     = word_no[IDX_BITS-1:0];
  assign a_hs    = a_valid && a_ready;

`ifdef TL_SLAVE_ERR_EN
  logic                    op_bad;
  logic                    size_bad;
  logic                    misaligned;
  logic                    below_base;
  logic                    out_of_range;
  logic [TL_ADDR_BITS-1:0] align_mask;

  assign op_put       = is_put_op(a_opcode);
  assign op_get       = (a_opcode == TL_A_GET);
  assign op_bad       = !op_put && !op_get;
  assign size_bad     = (a_size > TL_SIZE_BITS'(OFF_BITS));
  assign align_mask   = ~({TL_ADDR_BITS{1'b1}} << a_size);
  assign misaligned   = ((a_address & align_mask) != '0);
  assign below_base   = (a_address < BASE_ADDR);
  assign out_of_range = (word_no >= TL_ADDR_BITS'(DEPTH));
  assign denied       = op_bad | size_bad | misaligned | below_base | out_of_range;
  assign unused_bits  = ^{a_param, offset[OFF_BITS-1:0]};
`else
  // Without checking, anything that is not a Put reads like a Get and the index wraps.
  assign op_put      = is_put_op(a_opcode);
  assign op_get      = !op_put;
  assign denied      = 1'b0;
  assign unused_bits = ^{a_param, offset[OFF_BITS-1:0], word_no[TL_ADDR_BITS-1:IDX_BITS]};
`endif

  // Combinational read returns the word as it stood before this edge's write.
  assign rdata = mem_q[idx];

  always_ff @(posedge clk) begin
    if (a_hs && op_put && !denied) begin
      for (int b = 0; b < TL_DATA_BYTES; b++) begin
        if (a_mask[b]) begin
          mem_q[idx][8*b +: 8] <= a_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    resp_in        = '0;
    resp_in.size   = a_size;
    resp_in.source = a_source;
    resp_in.denied = denied;
    if (op_get) begin
      resp_in.opcode = TL_D_ACCESS_ACK_DATA;
      if (!denied) begin
        resp_in.data = rdata;
      end
    end else begin
      resp_in.opcode = TL_D_ACCESS_ACK;
    end
  end

  tl_resp_fifo #(
    .W (RESP_W)
  ) u_resp_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (a_valid),
    .push_ready_o (a_ready),
    .push_data_i  (resp_in),
    .pop_valid_o  (d_valid),
    .pop_ready_i  (d_ready),
    .pop_data_o   (resp_head),
    .count_o      (fifo_count)
  );

  assign d_opcode = resp_head.opcode;
  assign d_param  = 2'd0;
  assign d_size   = resp_head.size;
  assign d_source = resp_head.source;
  assign d_sink   = SINK_ID;
  assign d_denied = resp_head.denied;
  assign d_data   = resp_head.data;

  logic unused_count;
  assign unused_count = ^{fifo_count, unused_bits};

endmodule

// File: tb/tb_tl_ul_sram_slave.sv
// Bench for tl_ul_sram_slave: directed steps plus randomized traffic scored
// against a word-array reference model. Honors TL_SLAVE_ERR_EN when defined.
module tb_tl_ul_sram_slave;
  import tl_ul_sram_slave_pkg::*;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0;
  localparam logic [0:0]  SINK  = 1'b0;
  localparam int          EXP_W = 4 + 2 + TL_SIZE_BITS + TL_SOURCE_BITS + TL_SINK_BITS + 1 + TL_DATA_BITS;

  logic                      clk;
  logic                      rst;
  logic [2:0]                a_opcode;
  logic [2:0]                a_param;
  logic [TL_SIZE_BITS-1:0]   a_size;
  logic [TL_SOURCE_BITS-1:0] a_source;
  logic [TL_ADDR_BITS-1:0]   a_address;
  logic [TL_DATA_BYTES-1:0]  a_mask;
  logic [TL_DATA_BITS-1:0]   a_data;
  logic                      a_valid;
  logic                      a_ready;
  logic [3:0]                d_opcode;
  logic [1:0]                d_param;
  logic [TL_SIZE_BITS-1:0]   d_size;
  logic [TL_SOURCE_BITS-1:0] d_source;
  logic [TL_SINK_BITS-1:0]   d_sink;
  logic                      d_denied;
  logic [TL_DATA_BITS-1:0]   d_data;
  logic                      d_valid;
  logic                      d_ready;

  logic [EXP_W-1:0] exp_q[$];
  logic [31:0]      ref_mem [DEPTH];
  int               n_cmp = 0;
  int               n_fail = 0;
  int               n_rsp = 0;

  tl_ul_sram_slave #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .SINK_ID   (SINK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_opcode  (a_opcode),
    .a_param   (a_param),
    .a_size    (a_size),
    .a_source  (a_source),
    .a_address (a_address),
    .a_mask    (a_mask),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .d_opcode  (d_opcode),
    .d_param   (d_param),
    .d_size    (d_size),
    .d_source  (d_source),
    .d_sink    (d_sink),
    .d_denied  (d_denied),
    .d_data    (d_data),
    .d_valid   (d_valid),
    .d_ready   (d_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one request applied to a plain word array, in request order.
  function automatic logic [EXP_W-1:0] model_req(input logic [2:0] op, input logic [2:0] size,
                                                 input logic [3:0] src, input logic [31:0] addr,
                                                 input logic [3:0] mask, input logic [31:0] data);
    logic [31:0] word_no;
    int          idx;
    logic        den;
    logic        is_get;
    logic [31:0] rd;
    den     = 1'b0;
    word_no = (addr - BASE) / 32'(TL_DATA_BYTES);
`ifdef TL_SLAVE_ERR_EN
    is_get = (op == 3'd4);
    if (op != 3'd0 && op != 3'd1 && op != 3'd4) den = 1'b1;
    if (int'(size) > 2) den = 1'b1;
    if ((addr % (32'd1 << size)) != 32'd0) den = 1'b1;
    if (addr < BASE) den = 1'b1;
    if (word_no >= 32'(DEPTH)) den = 1'b1;
`else
    is_get = (op != 3'd0 && op != 3'd1);
`endif
    idx = int'(word_no % 32'(DEPTH));
    rd  = ref_mem[idx];
    if (!is_get && !den) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
      end
    end
    return {(is_get ? 4'd1 : 4'd0), 2'd0, size, src, SINK, den, ((is_get && !den) ? rd : 32'd0)};
  endfunction

  // driver tasks: called at posedge+1, return at posedge+1 after the handshake edge
  task automatic send_req(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                          input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                          input bit rand_bp, output int waited);
    a_opcode  = op;
    a_param   = 3'($urandom_range(0, 7));
    a_size    = size;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    a_valid   = 1'b1;
    waited    = 0;
    if (rand_bp) d_ready = 1'($urandom_range(0, 1));
    forever begin
      @(negedge clk);
      if (a_ready) break;
      waited++;
      if (waited > 50) begin
        check("a_ready_timeout", 64'(a_ready), 64'd1);
        break;
      end
      @(posedge clk); #1;
      if (rand_bp) d_ready = 1'($urandom_range(0, 1));
    end
    if (a_ready) exp_q.push_back(model_req(op, size, src, addr, mask, data));
    @(posedge clk); #1;
  endtask

  task automatic idle();
    a_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    a_valid = 1'b0;
    d_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (!rst && d_valid && d_ready) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        check("rsp", 64'({d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data}),
              64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int          w;
    int          rsp0;
    int          r;
    logic [2:0]  op;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] put_val;
    logic [2:0]  other_ops [5];
    other_ops = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

    rst = 1'b1; a_valid = 1'b0; d_ready = 1'b0;
    a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
    a_address = '0; a_mask = '0; a_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_d_valid",  64'(d_valid),  64'd0);
    check("rst_a_ready",  64'(a_ready),  64'd1);
    check("rst_d_opcode", 64'(d_opcode), 64'd0);
    check("rst_d_param",  64'(d_param),  64'd0);
    check("rst_d_size",   64'(d_size),   64'd0);
    check("rst_d_source", 64'(d_source), 64'd0);
    check("rst_d_sink",   64'(d_sink),   64'(SINK));
    check("rst_d_denied", 64'(d_denied), 64'd0);
    check("rst_d_data",   64'(d_data),   64'd0);
    @(posedge clk); #1;

    // fill every word so later Gets never see uninitialised SRAM
    d_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      send_req(3'd0, 3'd2, 4'(i), 32'(i * 4), 4'hF, $urandom(), 1'b0, w);
    end
    drain();

    // PutFull then Get of the same word
    send_req(3'd0, 3'd2, 4'd3, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, w);
    check("put_latency_valid", 64'(d_valid),  64'd1);
    check("put_ack_opcode",    64'(d_opcode), 64'd0);
    check("put_ack_source",    64'(d_source), 64'd3);
    check("put_ack_denied",    64'(d_denied), 64'd0);
    send_req(3'd4, 3'd2, 4'd7, 32'h10, 4'hF, 32'h0, 1'b0, w);
    check("get_opcode", 64'(d_opcode), 64'd1);
    check("get_data",   64'(d_data),   64'hDEADBEEF);

    // PutPartial over the low half
    send_req(3'd1, 3'd2, 4'd4, 32'h10, 4'h3, 32'h00001234, 1'b0, w);
    send_req(3'd4, 3'd2, 4'd5, 32'h10, 4'hF, 32'h0, 1'b0, w);
    check("partial_get_data", 64'(d_data), 64'hDEAD1234);
    drain();

    // backpressure: three Gets with d_ready low
    d_ready = 1'b0;
    send_req(3'd4, 3'd2, 4'd1, 32'h10, 4'hF, 32'h0, 1'b0, w);
    send_req(3'd4, 3'd2, 4'd2, 32'h14, 4'hF, 32'h0, 1'b0, w);
    check("bp_a_ready_full", 64'(a_ready), 64'd0);
    a_opcode = 3'd4; a_source = 4'd3; a_address = 32'h18; a_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_a_ready", 64'(a_ready), 64'd0);
      check("bp_head_stable",  64'(d_source), 64'd1);
    end
    @(posedge clk); #1;
    d_ready = 1'b1;
    send_req(3'd4, 3'd2, 4'd3, 32'h18, 4'hF, 32'h0, 1'b0, w);
    check("bp_third_waited", 64'(w != 0), 64'd1);
    drain();

    // throughput: 16 back-to-back Gets
    rsp0 = n_rsp;
    for (int i = 0; i < 16; i++) begin
      send_req(3'd4, 3'd2, 4'(i), 32'($urandom_range(0, DEPTH - 1) * 4), 4'hF, 32'h0, 1'b0, w);
      check("tput_no_stall", 64'(w), 64'd0);
      check("tput_d_valid",  64'(d_valid), 64'd1);
    end
    drain();
    check("tput_count", 64'(n_rsp - rsp0), 64'd16);

`ifdef TL_SLAVE_ERR_EN
    send_req(3'd4, 3'd2, 4'd9, 32'h400, 4'hF, 32'h0, 1'b0, w);
    check("err_get_denied", 64'(d_denied), 64'd1);
    check("err_get_opcode", 64'(d_opcode), 64'd1);
    check("err_get_data",   64'(d_data),   64'd0);
    send_req(3'd0, 3'd2, 4'd10, 32'h2, 4'hF, 32'hFFFFFFFF, 1'b0, w);
    check("err_put_denied", 64'(d_denied), 64'd1);
    send_req(3'd4, 3'd2, 4'd11, 32'h0, 4'hF, 32'h0, 1'b0, w);
    check("err_mem_unchanged", 64'(d_data), 64'(ref_mem[0]));
    drain();
`endif

    // randomized traffic with random D backpressure
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      op = 3'd0;
      else if (r < 6) op = 3'd1;
      else if (r < 9) op = 3'd4;
      else            op = other_ops[$urandom_range(0, 4)];
`ifdef TL_SLAVE_ERR_EN
      sz   = 3'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 1279));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'd3;
`else
      sz   = 3'($urandom_range(0, 2));
      addr = $urandom();
`endif
      send_req(op, sz, 4'($urandom_range(0, 15)), addr, 4'($urandom_range(0, 15)), $urandom(), 1'b1, w);
      if ($urandom_range(0, 3) == 0) idle();
    end
    drain();

    // reset with a full FIFO
    d_ready = 1'b0;
    put_val = $urandom();
    send_req(3'd0, 3'd2, 4'd5, 32'h20, 4'hF, put_val, 1'b0, w);
    send_req(3'd4, 3'd2, 4'd6, 32'h24, 4'hF, 32'h0, 1'b0, w);
    check("rst_pre_full", 64'(a_ready), 64'd0);
    a_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_d_valid",  64'(d_valid),  64'd0);
    check("midrst_a_ready",  64'(a_ready),  64'd1);
    check("midrst_d_data",   64'(d_data),   64'd0);
    check("midrst_d_source", 64'(d_source), 64'd0);
    @(posedge clk); #1;
    d_ready = 1'b1;
    send_req(3'd4, 3'd2, 4'd12, 32'h20, 4'hF, 32'h0, 1'b0, w);
    check("rst_put_retained", 64'(d_data), 64'(put_val));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_ul_sram_slave.md
# tl_ul_sram_slave

TileLink UL responder: terminates Channel A at a single-port on-chip SRAM and returns the matching Channel D responses. It is the slave-side endpoint that connects to the interconnect's `s0_*` port. Get, PutFullData and PutPartialData are served with a fixed one-cycle response latency. Responses are buffered in a 2-entry FIFO so the block sustains one transfer per cycle under D-channel backpressure.

## Interface
- `DEPTH`, 256: number of `TL_DATA_BYTES`-wide SRAM words (power of two).
- `BASE_ADDR`, 0: byte address of word 0.
- `SINK_ID`, 0: constant driven on `d_sink`.

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `a_opcode`  in  3  A opcode.
- `a_param`  in  3  ignored.
- `a_size`  in  `TL_SIZE_BITS`  log2 bytes.
- `a_source`  in  `TL_SOURCE_BITS`  requester tag.
- `a_address`  in  `TL_ADDR_BITS`  byte address.
- `a_mask`  in  `TL_DATA_BYTES`  byte enables.
- `a_data`  in  `TL_DATA_BYTES*8`  write data.
- `a_valid` / `a_ready`  in / out  1  A handshake.
- `d_opcode`  out  4  AccessAck=0, AccessAckData=1.
- `d_param`  out  2  always 0.
- `d_size`  out  `TL_SIZE_BITS`  echo of `a_size`.
- `d_source`  out  `TL_SOURCE_BITS`  echo of `a_source`.
- `d_sink`  out  `TL_SINK_BITS`  `SINK_ID`.
- `d_denied`  out  1  request rejected.
- `d_data`  out  `TL_DATA_BYTES*8`  read data; 0 for AccessAck and for denied Get.
- `d_valid` / `d_ready`  out / in  1  D handshake.

## Operation
- A handshake: `a_valid && a_ready`. `a_ready = (count != 2)`, registered-state only; there is no combinational path from `d_ready`.
- Word index: `(a_address - BASE_ADDR) >> log2(TL_DATA_BYTES)`.
- PutFullData (0) and PutPartialData (1):
  - At the handshake edge, write the bytes where `a_mask[i]=1`.
  - Push AccessAck with `d_data=0`.
- Get (4):
  - Read the indexed word at the handshake edge.
  - Push AccessAckData with the word as it stood before that edge.
  - Writes in earlier cycles are visible.
- Response FIFO (`count` 0..2):
  - Push on A handshake; pop on D handshake.
  - Simultaneous push and pop leaves `count` unchanged; the new entry goes behind the head.
  - `d_valid = (count != 0)`; all D fields are driven from the head entry.
  - Head fields stay stable while `d_valid && !d_ready`.
- Responses leave in request order; sources are never reordered.
- Other opcodes (Arithmetic, Logical, Intent): see Configuration.

## Timing
- Reset:
  - `count=0`, `d_valid=0`, `a_ready=1`.
  - All head registers zero: `d_opcode=0`, `d_size=0`, `d_source=0`, `d_denied=0`, `d_data=0`. `d_param=0`, `d_sink=SINK_ID`.
  - SRAM contents are not reset.
- Reset asserted mid-operation flushes the FIFO and drops pending responses. A write already handshaken before reset is retained.
- Latency: an A handshake in cycle N gives `d_valid` in cycle N+1 if the FIFO was empty or popped in N.
- Throughput: with `d_ready=1`, one request per cycle indefinitely (`count` stays at 1).
- Full: with `count=2`, `a_ready=0` until the cycle after a pop.

## Configuration
- `TL_SLAVE_ERR_EN` defined:
  - Denied (`d_denied=1`) on any of: unsupported opcode, `a_size > log2(TL_DATA_BYTES)`, address not aligned to `2^a_size`, `a_address < BASE_ADDR`, index ≥ `DEPTH`.
  - A denied request never writes the SRAM.
  - A denied Get returns AccessAckData with data 0. Any other denied opcode returns AccessAck.
- `TL_SLAVE_ERR_EN` undefined:
  - No checks; `d_denied` is tied 0.
  - The index wraps modulo `DEPTH`.
  - Unsupported opcodes are treated as Get.

## Structure
- `tl_pkg.vh` gains the opcode constants `TL_A_PUT_FULL` (0), `TL_A_PUT_PARTIAL` (1), `TL_A_GET` (4), `TL_D_ACCESS_ACK` (0), `TL_D_ACCESS_ACK_DATA` (1).
- Existing width macros are reused.
- One sub-module, `tl_resp_fifo`:
  - 2-entry, width-parameterised, synchronous active-high reset.
  - Outputs `count`, head data and push/pop handshakes.

## Test plan
Benches use `TL_DATA_BYTES=4`, `BASE_ADDR=0`, `DEPTH=256`.
- PutFull addr 0x10, mask 0xF, data 0xDEADBEEF, source 3 -> next cycle AccessAck, source 3, denied 0. A following Get at 0x10 returns 0xDEADBEEF.
- PutPartial addr 0x10, mask 0x3, data 0x00001234 over 0xDEADBEEF -> Get returns 0xDEAD1234.
- `d_ready=0`, three back-to-back Gets (sources 1, 2, 3) -> `a_ready` drops after the 2nd. Releasing `d_ready` delivers sources 1, 2, 3 in order with no loss.
- `d_ready=1`, 16 consecutive Gets -> 16 responses in 16 consecutive cycles, `a_ready` never low.
- `TL_SLAVE_ERR_EN` set:
  - Get at 0x400 -> AccessAckData, denied 1, data 0.
  - Put size 2 at 0x2 -> denied 1; memory unchanged.
- Reset with `count=2` -> next cycle `d_valid=0`, `a_ready=1`. Data from a pre-reset Put is still readable.
